mem_access_stage: RTL

//  MEM-stage responder for the EX/MEM request interface (row 00 nop, 01 read, 10 write).

---
 rtl/mem_access_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage responder: word-addressed data memory with fixed-latency loads/stores
//
// Purpose: accepts nop/read/write requests from EX/MEM, stalls upstream while a
// memory access is in flight, and registers the MEM/WB outputs (IR, result).
//
// Ports:
//   clk_i     in   1   clock, all state updates on posedge
//   rst_n_i   in   1   synchronous reset, active low
//   row_i     in   2   request: 00 nop, 01 read, 10 write, 11 illegal
//   data1_i   in   32  byte address (read/write) or ALU result (nop)
//   data2_i   in   32  store data
//   IR_i      in   32  instruction accompanying the request
//   stall_o   out  1   hold EX/MEM and earlier stages this cycle
//   result_o  out  32  load data or passed-through ALU result
//   IR_o      out  32  instruction for writeback
//   done_o    out  1   one-cycle pulse: outputs hold a completed memory op
//   err_o     out  1   one-cycle pulse: illegal row or bad address

module mem_access_stage #(
  parameter int MEM_BYTES  = 4096,
  parameter int ACCESS_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  row_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic [31:0] IR_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic [31:0] IR_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int DEPTH = MEM_BYTES / 4;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic            op_wr;
  logic            addr_bad;
  logic [AW-1:0]   idx;
  logic [31:0]     wdata;
  logic [31:0]     ir_lat;
  logic [31:0]     mem [DEPTH];

  logic            mem_req;
  logic            req_bad;
  logic            access;

  assign mem_req = (row_i == 2'b01) || (row_i == 2'b10);
  // Full 32-bit compare so addresses beyond the index width are caught as bad.
  assign req_bad = (data1_i[1:0] != 2'b00) || (data1_i >= 32'(MEM_BYTES));
  assign access  = (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          stall_o   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        // Request on row_i is still the one just served; never re-accept it.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (!rst_n_i) begin
      stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt      <= 4'd0;
      IR_o     <= 32'd0;
      result_o <= 32'd0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (mem_req) begin
            op_wr    <= row_i[1];
            addr_bad <= req_bad;
            idx      <= data1_i[AW+1:2];
            wdata    <= data2_i;
            ir_lat   <= IR_i;
            cnt      <= 4'(ACCESS_LAT - 1);
            err_o    <= 1'b0;
          end else begin
            IR_o     <= IR_i;
            result_o <= data1_i;
            err_o    <= (row_i == 2'b11);
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            IR_o     <= ir_lat;
            done_o   <= 1'b1;
            err_o    <= addr_bad;
            result_o <= (op_wr || addr_bad) ? 32'd0 : mem[idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
        end
        default: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
        end
      endcase
    end
  end

  // Memory is never cleared; a reset edge simply blocks the commit, which is
  // what drops a write that was still in BUSY.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && access && op_wr && !addr_bad) begin
      mem[idx] <= wdata;
    end
  end

endmodule
